// File: rtl/block_data_memory.sv
// block_data_memory
//   Line-granularity backing memory that answers cache miss/writeback requests.
//   One request is served at a time. Each request takes a fixed DELAY cycles
//   from acceptance to completion. Every transfer moves one whole line of
//   BLOCK_SIZE bytes.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset (control state only)
//   is_input_valid  request present this cycle
//   addr            line address; only the low CLOG2(NUM_BLOCKS) bits index the array
//   mem_read        request is a line read
//   mem_write       request is a line write (takes priority if both are set)
//   din             line write data
//   is_output_valid one-cycle pulse: dout carries freshly read data
//   dout            read data, held until the next read completes
//   mem_ready       a request can be accepted at the next rising edge
module block_data_memory #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_BLOCKS = 256,
    parameter int DELAY      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
);

    localparam int LINE_W = BLOCK_SIZE * 8;
    localparam int IDX_W  = $clog2(NUM_BLOCKS);
    localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [IDX_W-1:0]   req_idx_p0;
    logic               req_wr_p0;
    logic [LINE_W-1:0]  req_din_p0;
    logic [LINE_W-1:0]  mem [NUM_BLOCKS];

    logic accept;
    logic finish;

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^addr[31:IDX_W];

    // mem_ready is low only in BUSY, so it alone gates acceptance.
    assign accept = is_input_valid && mem_ready && (mem_read || mem_write);
    assign finish = (state == BUSY) && (counter == '0);

    // Request capture / completion control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= '0;
            mem_ready       <= 1'b1;
            is_output_valid <= 1'b0;
            dout            <= '0;
            req_idx_p0      <= '0;
            req_wr_p0       <= 1'b0;
        end else begin
            is_output_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= BUSY;
                        counter    <= CNT_W'(DELAY - 1);
                        mem_ready  <= 1'b0;
                        req_idx_p0 <= addr[IDX_W-1:0];
                        // Both op bits set is treated as a write.
                        req_wr_p0  <= mem_write;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (counter == '0) begin
                        state     <= DONE;
                        mem_ready <= 1'b1;
                        if (!req_wr_p0) begin
                            is_output_valid <= 1'b1;
                            dout            <= mem[req_idx_p0];
                        end
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage and latched write data: never cleared by reset. An aborted
    // write cannot commit because reset forces the state out of BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_din_p0 <= din;
        end
        if (finish && req_wr_p0) begin
            mem[req_idx_p0] <= req_din_p0;
        end
    end

endmodule
